instruction_fetch: RTL and testbench

- Front end of the uDLX pipeline; the consumer of the execute stage's redirect pair (new PC value and select strobe).
- Owns the architectural PC and issues one instruction-memory read at a time over a req/ack/rvalid handshake.
- Buffers the returned instruction, together with its PC and PC+step, for the decode stage.
- Honours decode stalls and squashes in-flight fetches on a redirect.

---
 rtl/instruction_fetch_pkg.sv | 11 +
 rtl/instruction_fetch_skid_buffer.sv | 40 ++++
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared fetch-stage types and defaults for the uDLX pipeline.
package instruction_fetch_pkg;
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } fetch_state_t;
    localparam int PC_WIDTH_DEFAULT          = 32;
    localparam int INSTRUCTION_WIDTH_DEFAULT = 32;
    localparam int PC_STEP_DEFAULT           = 4;
    localparam int RESET_PC_DEFAULT          = 0;
endpackage

// File: rtl/instruction_fetch_skid_buffer.sv
// fetch_skid_buffer: single-entry {instruction, pc} holding register with load/unload/flush.
module fetch_skid_buffer #(
    parameter int IW = 32,
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_unload,
    input  logic          i_flush,
    input  logic [IW-1:0] i_inst,
    input  logic [PW-1:0] i_pc,
    output logic          o_full,
    output logic [IW-1:0] o_inst,
    output logic [PW-1:0] o_pc
);
    logic          r_full;
    logic [IW-1:0] r_inst;
    logic [PW-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_inst <= '0;
            r_pc   <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_inst <= i_inst;
            r_pc   <= i_pc;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_inst = r_inst;
    assign o_pc   = r_pc;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, runs one imem read at a time and buffers words for decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH          = PC_WIDTH_DEFAULT,
    parameter int                  INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC          = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter logic [PC_WIDTH-1:0] PC_STEP           = PC_WIDTH'(PC_STEP_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_in,
    input  logic                         select_new_pc_in,
    input  logic [PC_WIDTH-1:0]          new_pc_in,
    output logic                         imem_req_out,
    output logic [PC_WIDTH-1:0]          imem_addr_out,
    input  logic                         imem_ack_in,
    input  logic                         imem_rvalid_in,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata_in,
    output logic                         inst_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]          pc_out,
    output logic [PC_WIDTH-1:0]          new_pc_out
);
    fetch_state_t                 r_state;
    logic                         r_discard;
    logic                         r_valid;
    logic [PC_WIDTH-1:0]          r_pc_reg;
    logic [INSTRUCTION_WIDTH-1:0] r_inst;
    logic [PC_WIDTH-1:0]          r_pc_out;
    logic [PC_WIDTH-1:0]          r_new_pc_out;

    logic                         w_skid_full;
    logic [INSTRUCTION_WIDTH-1:0] w_skid_inst;
    logic [PC_WIDTH-1:0]          w_skid_pc;
    logic                         w_ack;
    logic                         w_deliver;
    logic                         w_slot_free;
    logic                         w_from_skid;
    logic                         w_to_out;
    logic                         w_to_skid;
    logic [PC_WIDTH-1:0]          w_next_pc_out;

    // A full skid blocks new requests, so a delivery never meets a full skid.
    assign imem_req_out  = !rst && r_state == ST_FETCH && !w_skid_full;
    assign imem_addr_out = r_pc_reg;
    assign w_ack         = imem_req_out && imem_ack_in;
    assign w_deliver     = r_state == ST_WAIT && imem_rvalid_in && !r_discard && !select_new_pc_in;
    assign w_slot_free   = !r_valid || !stall_in;
    assign w_from_skid   = w_slot_free && w_skid_full && !select_new_pc_in;
    assign w_to_out      = w_slot_free && w_deliver && !w_skid_full;
    assign w_to_skid     = w_deliver && !w_slot_free;
    assign w_next_pc_out = w_from_skid ? w_skid_pc : r_pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_discard    <= 1'b0;
            r_valid      <= 1'b0;
            r_pc_reg     <= RESET_PC;
            r_inst       <= '0;
            r_pc_out     <= '0;
            r_new_pc_out <= '0;
        end else begin
            r_state   <= (r_state == ST_FETCH) ? (w_ack ? ST_WAIT : ST_FETCH)
                                               : (imem_rvalid_in ? ST_FETCH : ST_WAIT);
            // Marks the outstanding read as stale when a redirect overtakes it.
            r_discard <= (r_state == ST_FETCH) ? (w_ack && select_new_pc_in)
                                               : (!imem_rvalid_in && (r_discard || select_new_pc_in));
            r_pc_reg  <= select_new_pc_in ? new_pc_in : w_deliver ? r_pc_reg + PC_STEP : r_pc_reg;
            if (select_new_pc_in)
                r_valid <= 1'b0;
            else if (w_slot_free)
                r_valid <= w_skid_full || w_deliver;
            if (w_from_skid || w_to_out) begin
                r_inst       <= w_from_skid ? w_skid_inst : imem_rdata_in;
                r_pc_out     <= w_next_pc_out;
                r_new_pc_out <= w_next_pc_out + PC_STEP;
            end
        end
    end

    fetch_skid_buffer #(
        .IW(INSTRUCTION_WIDTH),
        .PW(PC_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_to_skid),
        .i_unload(w_from_skid),
        .i_flush (select_new_pc_in),
        .i_inst  (imem_rdata_in),
        .i_pc    (r_pc_reg),
        .o_full  (w_skid_full),
        .o_inst  (w_skid_inst),
        .o_pc    (w_skid_pc)
    );

    assign inst_valid_out  = r_valid;
    assign instruction_out = r_inst;
    assign pc_out          = r_pc_out;
    assign new_pc_out      = r_new_pc_out;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random stimulus against a queue-based model of the fetch stage.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        select_new_pc_in = 1'b0;
    logic [31:0] new_pc_in = '0;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in = 1'b0;
    logic        imem_rvalid_in = 1'b0;
    logic [31:0] imem_rdata_in = '0;
    logic        inst_valid_out;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic [31:0] new_pc_out;

    instruction_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .select_new_pc_in(select_new_pc_in),
        .new_pc_in       (new_pc_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_ack_in     (imem_ack_in),
        .imem_rvalid_in  (imem_rvalid_in),
        .imem_rdata_in   (imem_rdata_in),
        .inst_valid_out  (inst_valid_out),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .new_pc_out      (new_pc_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    // Model: queue of words handed to decode but not yet consumed (front is the visible output).
    ent_t        m_q[$];
    logic        m_out   = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_pc    = '0;
    logic        m_init  = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic sl, input logic [31:0] np,
                        input logic a, input logic rv, input logic [31:0] d);
        logic m_req;
        logic cons;
        logic got;
        @(negedge clk);
        rst = r;
        stall_in = s;
        select_new_pc_in = sl;
        new_pc_in = np;
        imem_ack_in = a;
        imem_rvalid_in = rv;
        imem_rdata_in = d;
        #1;
        m_req = !r && !m_out && m_q.size() < 2;
        if (m_init) begin
            chk("req", imem_req_out, m_req);
            if (m_req) chk("addr", imem_addr_out, m_pc);
            chk("valid", inst_valid_out, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("inst", instruction_out, m_q[0].inst);
                chk("pc", pc_out, m_q[0].pc);
                chk("new_pc", new_pc_out, m_q[0].pc + 32'd4);
            end
        end
        if (r) begin
            m_init = 1'b1;
            m_out = 1'b0;
            m_stale = 1'b0;
            m_pc = '0;
            m_q.delete();
        end else begin
            cons = m_q.size() > 0 && !s;
            got = m_out && rv;
            if (sl) m_q.delete();
            else if (cons) void'(m_q.pop_front());
            if (got) begin
                m_out = 1'b0;
                if (!m_stale && !sl) begin
                    m_q.push_back(ent_t'{inst: d, pc: m_pc});
                    m_pc = m_pc + 32'd4;
                end
                m_stale = 1'b0;
            end else if (m_out && sl) begin
                m_stale = 1'b1;
            end
            if (m_req && a) begin
                m_out = 1'b1;
                m_stale = sl;
            end
            if (sl) m_pc = np;
        end
    endtask

    initial begin
        logic r, s, sl, a, rv;
        logic [31:0] np;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_req", imem_req_out, 0);
        chk("rst_valid", inst_valid_out, 0);
        chk("rst_inst", instruction_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_new_pc", new_pc_out, 0);
        // first fetch
        step(0, 0, 0, 0, 1, 0, 0);
        chk("first_req", imem_req_out, 1);
        chk("first_addr", imem_addr_out, 32'h0);
        step(0, 0, 0, 0, 0, 1, 32'h20010005);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t1_valid", inst_valid_out, 1);
        chk("t1_inst", instruction_out, 32'h20010005);
        chk("t1_pc", pc_out, 32'h0);
        chk("t1_new_pc", new_pc_out, 32'h4);
        chk("t1_next_addr", imem_addr_out, 32'h4);
        // sequential stream
        step(0, 0, 0, 0, 0, 1, 32'hA1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("seq_pc4", pc_out, 32'h4);
        step(0, 0, 0, 0, 0, 1, 32'hA2);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("seq_pc8", pc_out, 32'h8);
        step(0, 0, 0, 0, 0, 1, 32'hA3);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("seq_pcC", pc_out, 32'hC);
        chk("seq_instC", instruction_out, 32'hA3);
        // stall with skid fill
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hD0);
        step(0, 1, 0, 0, 1, 0, 0);
        chk("stall_addr", imem_addr_out, 32'h4);
        step(0, 1, 0, 0, 0, 1, 32'hD1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 1, 0, 0);
            chk("stall_noreq", imem_req_out, 0);
            chk("stall_hold", instruction_out, 32'hD0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rel_pc0", pc_out, 32'h0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("rel_pc4", pc_out, 32'h4);
        chk("rel_inst", instruction_out, 32'hD1);
        chk("rel_addr", imem_addr_out, 32'h8);
        // redirect while waiting
        step(0, 0, 1, 32'h100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hDEAD);
        chk("rd_drop_valid", inst_valid_out, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("rd_valid", inst_valid_out, 0);
        chk("rd_addr", imem_addr_out, 32'h100);
        step(0, 0, 0, 0, 0, 1, 32'hB0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rd_pc", pc_out, 32'h100);
        chk("rd_new_pc", new_pc_out, 32'h104);
        // redirect with same-cycle rvalid while stalled
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hB1);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 1, 32'h40, 0, 1, 32'hBAD);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("rs_valid", inst_valid_out, 0);
        chk("rs_addr", imem_addr_out, 32'h40);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hB2);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rs_pc", pc_out, 32'h40);
        // wrap
        step(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("wr_addr", imem_addr_out, 32'hFFFFFFFC);
        step(0, 0, 0, 0, 0, 1, 32'hB3);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("wr_pc", pc_out, 32'hFFFFFFFC);
        chk("wr_new_pc", new_pc_out, 32'h0);
        chk("wr_next_addr", imem_addr_out, 32'h0);
        // reset during WAIT, then a late rvalid
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hBEEF);
        chk("lr_addr", imem_addr_out, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lr_valid", inst_valid_out, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hC0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lr_inst", instruction_out, 32'hC0);
        chk("lr_pc", pc_out, 32'h0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom % 150) == 0;
            s  = ($urandom % 3) == 0;
            sl = ($urandom % 12) == 0;
            np = ($urandom % 4 == 0) ? 32'hFFFFFFF8 : $urandom;
            a  = !m_out && m_q.size() < 2 && ($urandom % 2 == 0);
            rv = m_out && ($urandom % 2 == 0);
            step(r, s, sl, np, a, rv, $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
